// File: rtl/control_mac_filtro.sv
// ---------------------------------------------------------------------------
// control_mac_filtro
//   Sequencer for the filter multiply-accumulate datapath. Each accepted
//   new-sample strobe runs one output-sample sequence:
//     CLEAR (shift sample in, clear accumulator)
//     MAC   (TAPS products, tap address 0..TAPS-1)
//     WAIT  (PIPE cycles for the multiplier/adder pipeline)
//     TRUNC (drop ban_list for one cycle so the truncation stage updates)
//     DONE  (one-cycle done pulse)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   new-sample strobe
//   overrun_clr in   clears sticky overrun flag
//   addr        out  coefficient / delay-line tap index
//   shift_en    out  delay-line shift (loads new sample)
//   acc_clr     out  synchronous accumulator clear
//   acc_en      out  accumulate current product
//   ban_list    out  truncation hold: 1 = hold, 0 = update
//   done        out  one-cycle pulse, truncated result valid next cycle
//   busy        out  high in every state except IDLE
//   overrun     out  sticky: start seen while busy
//
// Every output is a flop; its next value is decoded from the next state, so
// no input reaches an output without passing through a register.
// ---------------------------------------------------------------------------
module control_mac_filtro #(
    parameter int TAPS   = 5,
    parameter int ADDR_W = 3,
    parameter int PIPE   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              overrun_clr,
    output logic [ADDR_W-1:0] addr,
    output logic              shift_en,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              ban_list,
    output logic              done,
    output logic              busy,
    output logic              overrun
);

    localparam int CNT_W = (PIPE > 1) ? $clog2(PIPE) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TAPS - 1);
    // Loaded on WAIT entry; guarded so PIPE=0 does not produce -1.
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'((PIPE > 0) ? PIPE - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_WAIT,
        S_TRUNC,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              shift_en_q, shift_en_d;
    logic              acc_clr_q, acc_clr_d;
    logic              acc_en_q, acc_en_d;
    logic              ban_list_q, ban_list_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                state_d = S_MAC;
                addr_d  = '0;
            end
            S_MAC: begin
                if (addr_q == LAST_ADDR) begin
                    // Leave MAC with addr back at 0; never wrap past TAPS-1.
                    addr_d  = '0;
                    cnt_d   = CNT_INIT;
                    state_d = (PIPE > 0) ? S_WAIT : S_TRUNC;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_TRUNC;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_TRUNC: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        shift_en_d = (state_d == S_CLEAR);
        acc_clr_d  = (state_d == S_CLEAR);
        acc_en_d   = (state_d == S_MAC);
        ban_list_d = (state_d != S_TRUNC);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d != S_IDLE);

        // Set has priority over clear when both land in the same cycle.
        if (start && busy_q)   overrun_d = 1'b1;
        else if (overrun_clr)  overrun_d = 1'b0;
        else                   overrun_d = overrun_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            shift_en_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            acc_en_q   <= 1'b0;
            ban_list_q <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            shift_en_q <= shift_en_d;
            acc_clr_q  <= acc_clr_d;
            acc_en_q   <= acc_en_d;
            ban_list_q <= ban_list_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign addr     = addr_q;
    assign shift_en = shift_en_q;
    assign acc_clr  = acc_clr_q;
    assign acc_en   = acc_en_q;
    assign ban_list = ban_list_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: doc/control_mac_filtro.md
Name: control_mac_filtro

Overview:
- Sequencer for the filter multiply-accumulate datapath.
- On each new-sample strobe it:
  - shifts the sample into the delay line,
  - clears the accumulator,
  - steps the tap/coefficient address through TAPS products,
  - waits out the multiplier/adder pipeline,
  - opens the saturating truncation stage for exactly one cycle via its hold (Ban_List) input.
- Sits between the ADC/sample-rate strobe and the multiplier, accumulator and truncation blocks.

Parameters:
- TAPS, 5, number of filter coefficients/products per output sample (>=1).
- ADDR_W, 3, width of tap address (2^ADDR_W >= TAPS).
- PIPE, 2, cycles from last acc_en to valid accumulator sum (>=0).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  new-sample strobe, sampled on rising clk.
- overrun_clr  input  1  clears sticky overrun flag.
- addr  output  ADDR_W  coefficient/delay-line tap index.
- shift_en  output  1  delay-line shift (loads new sample).
- acc_clr  output  1  synchronous clear of accumulator.
- acc_en  output  1  accumulate current product.
- ban_list  output  1  truncation hold: 1 = hold last output, 0 = update.
- done  output  1  one-cycle pulse, truncated result valid next cycle.
- busy  output  1  high in every state except IDLE.
- overrun  output  1  sticky: start arrived while busy.

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-high.
- All outputs are Moore decodes of registered state/counters. There is no combinational path from start or overrun_clr to any output.
- Reset values: state=IDLE, addr=0, shift_en=0, acc_clr=0, acc_en=0, ban_list=1, done=0, busy=0, overrun=0, wait counter=0.
- IDLE:
  - ban_list=1, busy=0.
  - start=1 → CLEAR.
- CLEAR (1 cycle):
  - shift_en=1, acc_clr=1, addr=0, busy=1.
  - → MAC.
- MAC (TAPS cycles):
  - acc_en=1; addr = 0,1,...,TAPS-1, one per cycle.
  - After the cycle with addr=TAPS-1: → WAIT if PIPE>0, else → TRUNC.
  - addr returns to 0 on leaving MAC (no wrap past TAPS-1).
- WAIT (PIPE cycles):
  - All strobes low; addr=0; down-counter loaded with PIPE-1 on entry.
  - Exit to TRUNC when counter=0.
- TRUNC (1 cycle):
  - ban_list=0; truncation stage samples the sum.
  - → DONE.
- DONE (1 cycle):
  - done=1, ban_list=1.
  - → IDLE.
- Latency: start sampled at edge 0.
  - CLEAR in cycle 1.
  - MAC in cycles 2..TAPS+1.
  - TRUNC in cycle TAPS+PIPE+2.
  - done in cycle TAPS+PIPE+3, i.e. 10 for defaults.
  - Minimum start spacing without overrun: TAPS+PIPE+4 cycles.
- start while busy=1 (including the DONE cycle):
  - Ignored; the sequence continues unaffected.
  - overrun set to 1 on the next edge.
- overrun_clr:
  - Clears overrun on the next edge.
  - If set and clear occur in the same cycle, set wins.
- start held high continuously:
  - Retriggers from IDLE each time IDLE is reached.
  - Flags overrun on each busy cycle it is seen.
- Reset asserted mid-sequence:
  - Immediately forces reset values, so ban_list=1 and the truncation output is held.
  - No done pulse is generated.
  - After reset deasserts, the first edge starts in IDLE.
- TAPS=1: MAC lasts exactly one cycle with addr=0.
- PIPE=0: WAIT state is never entered.

Test Plan:
- Defaults, reset, then single start pulse at edge 0 → all of the following:
  - shift_en and acc_clr high in cycle 1.
  - acc_en high in cycles 2-6 with addr 0,1,2,3,4.
  - ban_list=0 only in cycle 9.
  - done pulse in cycle 10.
  - busy low from cycle 11.
- Two starts spaced 11 cycles apart → two identical sequences, overrun stays 0. Spacing 6 → second start ignored, overrun=1, only one done pulse.
- Start during the DONE cycle → overrun=1, no new sequence. overrun_clr and a new busy-start in the same cycle → overrun remains 1.
- Reset asserted in cycle 4 (mid-MAC) → all outputs return to reset values asynchronously (ban_list=1, addr=0, busy=0), and no done pulse follows.
- TAPS=1, PIPE=0 → CLEAR in cycle 1, MAC in cycle 2 (addr 0), TRUNC in cycle 3, done in cycle 4.
- start held high for 40 cycles → done pulses at cycles 10, 21, 32, and overrun=1 after the first busy cycle.
